// File: rtl/bam_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bam_pkg;

  // Control states of the multiplier sequencer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the row counter: must index rows 0..width-1 of the multiplier
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bam_row.sv
// One partial-product row: ripple chain of AND-add cells adding (a & b_bit) to the previous upper half.
// Latency: combinational.
// Backpressure: none (pure datapath). With BAM_MULT_SIGNED_EN the Baugh-Wooley cell inversions are applied.
module bam_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
`ifdef BAM_MULT_SIGNED_EN
  input  logic             msb_row,
`endif
  input  logic [WIDTH-1:0] pre,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic pp;
`ifdef BAM_MULT_SIGNED_EN
    // Invert the partial product where exactly one of (row, column) is the sign position
    localparam logic MSB_COL = (i == WIDTH - 1);
    assign pp = (a[i] & b_bit) ^ (msb_row ^ MSB_COL);
`else
    assign pp = a[i] & b_bit;
`endif
    assign sum[i]     = pp ^ pre[i] ^ carry[i];
    assign carry[i+1] = (pp & pre[i]) | (pp & carry[i]) | (pre[i] & carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/bam_seq_mult.sv
// Sequential WIDTH x WIDTH multiplier, one partial-product row per clock (signed Baugh-Wooley if BAM_MULT_SIGNED_EN).
// Latency: out_valid rises WIDTH+1 edges after the acceptance edge, independent of operand values.
// Backpressure: in_ready only in IDLE; the product is held with out_valid until out_ready is seen.
module bam_seq_mult
  import bam_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

`ifdef BAM_MULT_SIGNED_EN
  // Baugh-Wooley correction: a one at bit WIDTH and at bit 2*WIDTH-1
  localparam logic [2*WIDTH-1:0] ONE     = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] BW_CORR = (ONE << WIDTH) | (ONE << (2*WIDTH-1));
`endif

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     row_sum;
  logic                 row_cout;
  logic [2*WIDTH-1:0]   result;

  bam_row #(.WIDTH(WIDTH)) u_row (
    .a      (a_q),
    .b_bit  (b_q[cnt_q]),
`ifdef BAM_MULT_SIGNED_EN
    .msb_row(cnt_q == LAST_ROW),
`endif
    .pre    (acc_q[2*WIDTH-1:WIDTH]),
    .sum    (row_sum),
    .cout   (row_cout)
  );

`ifdef BAM_MULT_SIGNED_EN
  assign result = acc_q + BW_CORR;
`else
  assign result = acc_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, WIDTH row cycles in RUN, wait for handshake in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_ROW) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, accumulate one row per RUN cycle, latch the product in DONE.
  // The first DONE cycle registers the (corrected) product, so out_valid lands one edge after RUN ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= {row_cout, row_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          if (!out_valid_q) begin
            product_q   <= result;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_bam_seq_mult.sv
// Directed bench for bam_seq_mult (WIDTH=8): vector table plus hand sequences for multi-cycle cases.
// Latency: checks out_valid arrives exactly WIDTH+1 edges after acceptance.
// Backpressure: exercises out_ready held low in DONE and in_valid asserted while busy.
module tb_bam_seq_mult;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bam_seq_mult #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble the inputs to prove they were registered
  task automatic start_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    tick;
    in_valid = 1'b0;
    a = ~va;
    b = ~vb;
  endtask

  // Count edges until out_valid; 0 means it never came within the budget
  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] exp);
    int lat;
    start_op(name, va, vb);
    wait_result(lat);
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_product"}, 32'(product), 32'(exp));
    if (lat != 0) handshake(name);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    int   seen;

`ifdef BAM_MULT_SIGNED_EN
    vecs[0] = '{a: 8'hFF, b: 8'hFF, exp: 16'h0001};  // -1 * -1
    vecs[1] = '{a: 8'h80, b: 8'h7F, exp: 16'hC080};  // -128 * 127
    vecs[2] = '{a: 8'h05, b: 8'hFD, exp: 16'hFFF1};  // 5 * -3
    vecs[3] = '{a: 8'h80, b: 8'h80, exp: 16'h4000};  // -128 * -128
    vecs[4] = '{a: 8'h7F, b: 8'h7F, exp: 16'h3F01};  // 127 * 127
    vecs[5] = '{a: 8'h00, b: 8'h9C, exp: 16'h0000};  // 0 * -100
    vecs[6] = '{a: 8'h0D, b: 8'h0B, exp: 16'h008F};  // 13 * 11
    vecs[7] = '{a: 8'hF6, b: 8'h0A, exp: 16'hFF9C};  // -10 * 10
`else
    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   exp: 16'd0};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};
    vecs[5] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};
    vecs[6] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450};
    vecs[7] = '{a: 8'd255, b: 8'd1,   exp: 16'd255};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick;
    tick;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_product",   32'(product),   32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Backpressure: product held five cycles with out_ready low
    start_op("bp", 8'd7, 8'd9);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'(W + 1));
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_hold_valid",   32'(out_valid), 32'd1);
      check("bp_hold_product", 32'(product),   32'd63);
      check("bp_hold_ready",   32'(in_ready),  32'd0);
      check("bp_hold_busy",    32'(busy),      32'd1);
    end
    handshake("bp");

    // in_valid with new operands while running must be ignored
    start_op("ign", 8'd21, 8'd3);
    repeat (2) tick;
    in_valid = 1'b1;
    a = 8'd100;
    b = 8'd100;
    check("ign_ready_low", 32'(in_ready), 32'd0);
    repeat (3) tick;
    in_valid = 1'b0;
    wait_result(lat);
    check("ign_latency", 32'(lat), 32'(W + 1 - 5));
    check("ign_product", 32'(product), 32'd63);
    if (lat != 0) handshake("ign");
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      tick;
      if (out_valid || !in_ready) seen++;
    end
    check("ign_single_result", 32'(seen), 32'd0);

    // Reset in the fourth RUN cycle abandons the operation
    start_op("rst_mid", 8'd50, 8'd60);
    repeat (3) tick;
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_in_ready",  32'(in_ready),  32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy",      32'(busy),      32'd0);
    check("rst_mid_product",   32'(product),   32'd0);
    seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      tick;
      if (out_valid) seen++;
    end
    check("rst_mid_no_result", 32'(seen), 32'd0);
    run_vec("after_rst", 8'd12, 8'd12, 16'd144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
